// File: rtl/inert_spi_resp.sv
// SPI-mode-3 slave register file for an inertial sensor: sample capture, INT and setup tracking.
// Optional overrun flag (ovr, STATUS[7]) is built only when INERT_RESP_OVR_EN is defined.
module inert_spi_resp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl_vld,
  input  logic [95:0] smpl_data,
  output logic        setup_done,
  output logic        ovr
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned NDATA   = 12;

  localparam logic [CNT_W-1:0]  CNT_CMD  = CNT_W'(7);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(16);

  localparam logic [ADDR_W-1:0] A_INT1   = 7'h0D;
  localparam logic [ADDR_W-1:0] A_WHO    = 7'h0F;
  localparam logic [ADDR_W-1:0] A_CTRL1  = 7'h10;
  localparam logic [ADDR_W-1:0] A_CTRL2  = 7'h11;
  localparam logic [ADDR_W-1:0] A_STATUS = 7'h1E;
  localparam logic [ADDR_W-1:0] A_DLO    = 7'h22;
  localparam logic [ADDR_W-1:0] A_DHI    = 7'h2D;
  localparam logic [BYTE_W-1:0] WHO_VAL  = 8'h6A;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;

  state_e state_q, state_d;

  logic [2:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic       ss_fall, ss_rise, ss_hi, sclk_rise, sclk_fall, mosi_bit;

  logic [CNT_W-1:0]   cnt_q;
  logic [FRAME_W-1:0] rx_q;
  logic [BYTE_W-1:0]  tx_q;
  logic               rd_q, miso_q;
  logic               shift_en, load_tx, tx_shift;

  logic [BYTE_W-1:0]  int1_ctrl_q, ctrl1_q, ctrl2_q;
  logic [NDATA-1:0][BYTE_W-1:0] data_q;
  logic [95:0]        shadow_q;
  logic               pend_q, upd_q, int_q, setup_done_q;

  logic [BYTE_W-1:0]  cmd_byte, rd_byte;
  logic [ADDR_W-1:0]  cmd_addr, fr_addr;
  logic [BYTE_W-1:0]  fr_data;
  logic               frame_done, wr_commit, rd_done;
  logic               upd_direct, data_upd;

  // Synchronizers track their inputs through reset so no false SS_n edge appears afterwards
  always_ff @(posedge clk) begin
    ss_sync_q   <= {ss_sync_q[1:0], SS_n};
    sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
    mosi_sync_q <= {mosi_sync_q[1:0], MOSI};
  end

  assign ss_fall   = ~ss_sync_q[1] &  ss_sync_q[2];
  assign ss_rise   =  ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_hi     =  ss_sync_q[1];
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign mosi_bit  =  mosi_sync_q[2];

  assign cmd_byte   = {rx_q[6:0], mosi_bit};
  assign cmd_addr   = cmd_byte[6:0];
  assign fr_addr    = rx_q[14:8];
  assign fr_data    = rx_q[7:0];
  assign frame_done = ss_rise && (cnt_q == CNT_FULL);
  assign wr_commit  = frame_done && !rx_q[15];
  assign rd_done    = frame_done &&  rx_q[15];

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = CMD;
      CMD:     if (sclk_rise && (cnt_q == CNT_CMD)) state_d = DATA;
      DATA:    if (sclk_rise && (cnt_q == CNT_LAST)) state_d = DONE;
      default: state_d = state_q;
    endcase
    if (ss_rise) state_d = IDLE;
  end

  // FSM control outputs
  always_comb begin
    shift_en = 1'b0;
    load_tx  = 1'b0;
    tx_shift = 1'b0;
    case (state_q)
      CMD: begin
        shift_en = sclk_rise;
        load_tx  = sclk_rise && (cnt_q == CNT_CMD) && cmd_byte[7];
      end
      DATA: begin
        shift_en = sclk_rise;
        tx_shift = sclk_fall && rd_q;
      end
      default: ;
    endcase
  end

  // Read mux for the address just received
  always_comb begin
    rd_byte = '0;
    if ((cmd_addr >= A_DLO) && (cmd_addr <= A_DHI)) begin
      rd_byte = data_q[4'(cmd_addr - A_DLO)];
    end else begin
      case (cmd_addr)
        A_WHO:    rd_byte = WHO_VAL;
        A_INT1:   rd_byte = int1_ctrl_q;
        A_CTRL1:  rd_byte = ctrl1_q;
        A_CTRL2:  rd_byte = ctrl2_q;
        A_STATUS: rd_byte = {ovr, 6'b0, int_q};
        default:  rd_byte = '0;
      endcase
    end
  end

  // Frame shifter and MISO driver; the first fall after the load re-presents the MSB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rx_q   <= '0;
      tx_q   <= '0;
      rd_q   <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      if (ss_fall) begin
        cnt_q <= '0;
        rx_q  <= '0;
        rd_q  <= 1'b0;
      end else if (shift_en && (cnt_q < CNT_FULL)) begin
        rx_q  <= {rx_q[14:0], mosi_bit};
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (load_tx) begin
        tx_q   <= rd_byte;
        miso_q <= rd_byte[7];
        rd_q   <= 1'b1;
      end else if (tx_shift) begin
        miso_q <= tx_q[7];
        tx_q   <= {tx_q[6:0], 1'b0};
      end
      if (ss_fall || ss_rise) begin
        miso_q <= 1'b0;
        tx_q   <= '0;
      end
    end
  end

  // Control registers, committed only on a complete write frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int1_ctrl_q  <= '0;
      ctrl1_q      <= '0;
      ctrl2_q      <= '0;
      setup_done_q <= 1'b0;
    end else if (wr_commit) begin
      case (fr_addr)
        A_INT1: begin
          int1_ctrl_q <= fr_data;
          if (fr_data != '0) setup_done_q <= 1'b1;
        end
        A_CTRL1: ctrl1_q <= fr_data;
        A_CTRL2: ctrl2_q <= fr_data;
        default: ;
      endcase
    end
  end

  assign upd_direct = smpl_vld && ss_hi;
  assign data_upd   = upd_direct || (ss_rise && pend_q);

  // Sample capture; a sample arriving mid-transaction waits in the shadow until SS_n rises
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      upd_q    <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      upd_q <= data_upd;
      if (upd_direct)   data_q <= smpl_data;
      else if (data_upd) data_q <= shadow_q;
      if (data_upd) pend_q <= 1'b0;
      if (smpl_vld && !ss_hi) begin
        shadow_q <= smpl_data;
        pend_q   <= 1'b1;
      end
      if (rd_done && (fr_addr == A_DHI)) int_q <= 1'b0;
      if (upd_q && int1_ctrl_q[1])       int_q <= 1'b1;
    end
  end

`ifdef INERT_RESP_OVR_EN
  logic ovr_q;

  // Overrun: fresh data landed while the previous one was still flagged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
    end else begin
      if (rd_done && (fr_addr == A_STATUS)) ovr_q <= 1'b0;
      if (data_upd && int_q)                ovr_q <= 1'b1;
    end
  end

  assign ovr = ovr_q;
`else
  assign ovr = 1'b0;
`endif

  assign MISO       = miso_q;
  assign INT        = int_q;
  assign setup_done = setup_done_q;

endmodule

// File: tb/tb_inert_spi_resp.sv
// Directed bench for inert_spi_resp: SPI frames bit-banged at 1/20 of clk, read bytes scoreboarded.
module tb_inert_spi_resp;

  localparam time CLK_P = 10ns;
  localparam time HALF  = 100ns;

  logic        clk = 1'b0;
  logic        rst_n, SS_n, SCLK, MOSI, smpl_vld;
  logic [95:0] smpl_data;
  logic        MISO, INT, setup_done, ovr;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  logic [95:0] s1, s2, s3, s4;
  logic [7:0]  got;
  logic        unused_s;

  inert_spi_resp dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT), .smpl_vld(smpl_vld), .smpl_data(smpl_data),
    .setup_done(setup_done), .ovr(ovr)
  );

  always #(CLK_P/2) clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_smpl(input logic [95:0] d);
    @(negedge clk);
    smpl_vld  = 1'b1;
    smpl_data = d;
    @(negedge clk);
    smpl_vld  = 1'b0;
  endtask

  // One SCLK cycle: master drives on fall, samples MISO just before rise
  task automatic sclk_bit(input logic b, output logic s);
    SCLK = 1'b0;
    MOSI = b;
    #HALF;
    s = MISO;
    SCLK = 1'b1;
    #HALF;
  endtask

  // Full SS_n-framed transfer of nbits; optional sample pulse before bit pulse_at
  task automatic spi_xfer(input logic [15:0] frame, input int nbits, input int pulse_at,
                          input logic [95:0] pdata, output logic [7:0] rd);
    logic s;
    rd = '0;
    SS_n = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      if (i == pulse_at) pulse_smpl(pdata);
      sclk_bit(frame[15-i], s);
      if (i >= 8) rd = {rd[6:0], s};
    end
    #HALF;
    SS_n = 1'b1;
    #(8*CLK_P);
  endtask

  task automatic spi_write(input logic [15:0] frame);
    logic [7:0] d;
    spi_xfer(frame, 16, -1, '0, d);
  endtask

  task automatic rd_chk(input logic [7:0] cmd, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    spi_xfer({cmd, 8'h00}, 16, -1, '0, d);
    check(tag_q.pop_front(), d, exp_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    smpl_vld = 1'b0; smpl_data = '0;
    s1 = {16'hF00D, 16'hBEEF, 16'hCAFE, 16'h5678, 16'h9ABC, 16'h1234};
    s2 = {16'hF00D, 16'hBEEF, 16'hCAFE, 16'h5678, 16'h9ABC, 16'h4321};
    s3 = {16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C};
    s4 = {16'h1112, 16'h1314, 16'h1516, 16'h1718, 16'h191A, 16'h1B1C};
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("rst_miso", {7'b0, MISO}, 8'h00);
    check("rst_int", {7'b0, INT}, 8'h00);
    check("rst_setup", {7'b0, setup_done}, 8'h00);
    check("rst_ovr", {7'b0, ovr}, 8'h00);

    rd_chk(8'h8F, 8'h6A, "who_am_i");
    check("setup_after_who", {7'b0, setup_done}, 8'h00);

    spi_write(16'h0D02);
    check("setup_done", {7'b0, setup_done}, 8'h01);
    check("miso_idle", {7'b0, MISO}, 8'h00);
    rd_chk(8'h8D, 8'h02, "int1_ctrl");
    rd_chk(8'h80, 8'h00, "data_before_smpl");

    pulse_smpl(s1);
    repeat (4) @(negedge clk);
    check("int_set", {7'b0, INT}, 8'h01);
    rd_chk(8'hA2, 8'h34, "ptch_l");
    rd_chk(8'hA3, 8'h12, "ptch_h");
    rd_chk(8'hA6, 8'h78, "yaw_l");
    check("int_hold", {7'b0, INT}, 8'h01);
    rd_chk(8'hAD, 8'hF0, "az_h");
    check("int_clr", {7'b0, INT}, 8'h00);

    // Sample lands mid-read: old byte out, new byte on the next read
    exp_q.push_back(8'h34);
    tag_q.push_back("shadow_old");
    spi_xfer(16'hA200, 16, 10, s2, got);
    check(tag_q.pop_front(), got, exp_q.pop_front());
    repeat (3) @(negedge clk);
    check("int_after_shadow", {7'b0, INT}, 8'h01);
    rd_chk(8'hA2, 8'h21, "shadow_new");
    rd_chk(8'hAD, 8'hF0, "az_h_clear");
    check("int_clr2", {7'b0, INT}, 8'h00);

    // Aborted write of CTRL1 after 12 bits
    spi_xfer(16'h1055, 12, -1, '0, got);
    rd_chk(8'h90, 8'h00, "ctrl1_abort");
    spi_write(16'h10A5);
    spi_write(16'h1155);
    rd_chk(8'h90, 8'hA5, "ctrl1_full");
    rd_chk(8'h91, 8'h55, "ctrl2_full");
    spi_write(16'h0F00);
    rd_chk(8'h8F, 8'h6A, "who_ro");
    rd_chk(8'hFF, 8'h00, "unmapped");

    // Two samples without draining 0x2D
    pulse_smpl(s3);
    repeat (4) @(negedge clk);
    pulse_smpl(s4);
    repeat (4) @(negedge clk);
    check("int_ovr", {7'b0, INT}, 8'h01);
`ifdef INERT_RESP_OVR_EN
    check("ovr_set", {7'b0, ovr}, 8'h01);
    rd_chk(8'h9E, 8'h81, "status");
`else
    check("ovr_set", {7'b0, ovr}, 8'h00);
    rd_chk(8'h9E, 8'h01, "status");
`endif
    check("ovr_clr", {7'b0, ovr}, 8'h00);
    rd_chk(8'hA2, 8'h1C, "ptch_l_latest");

    // Reset in the middle of a frame; SS_n stays low so the rest must be ignored
    SS_n = 1'b0;
    #HALF;
    for (int i = 0; i < 5; i++) sclk_bit(1'b0, unused_s);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_int", {7'b0, INT}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] f;
      f = 16'h0D04;
      sclk_bit(f[15-i], unused_s);
    end
    #HALF;
    SS_n = 1'b1;
    #(8*CLK_P);
    check("rst_mid_nocommit", {7'b0, setup_done}, 8'h00);
    rd_chk(8'h8D, 8'h00, "int1_after_rst");
    spi_write(16'h0D04);
    check("setup_again", {7'b0, setup_done}, 8'h01);
    rd_chk(8'h8D, 8'h04, "int1_fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
